// File: rtl/wb_line_mem_slave.sv
// Wishbone classic-cycle line memory slave with programmable response latency,
// byte-masked writes and periodic refresh windows that answer requests with RTY.
//   state   | meaning
//   S_IDLE  | waiting for CYC&STB; RTY if refresh busy, else latch request
//   S_WAIT  | counting down latency; abort to idle if CYC or STB drops
//   S_RESP  | ACK pulse; read data already registered, write commits on exit
//   S_RETRY | RTY pulse, no memory effect
module wb_line_mem_slave #(
  parameter int DATA_WIDTH     = 128,
  parameter int ADDR_WIDTH     = 12,
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    CYC,
  input  logic                    STB,
  input  logic                    WE,
  input  logic [ADDR_WIDTH-1:0]   ADR,
  input  logic [DATA_WIDTH/8-1:0] SEL,
  input  logic [DATA_WIDTH-1:0]   DAT_M,
  output logic [DATA_WIDTH-1:0]   DAT_S,
  output logic                    ACK,
  output logic                    RTY
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RETRY} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [7:0]              r_lat_cnt;
  logic [RW-1:0]           r_ref_cnt;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic                    r_we;
  logic [NB-1:0]           r_sel;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [DATA_WIDTH-1:0]   r_dat_s;
  logic                    r_ack;
  logic                    r_rty;
  logic [DATA_WIDTH-1:0]   r_mem [0:(1<<ADDR_WIDTH)-1];

  logic                    w_req;
  logic                    w_busy;
  logic                    w_accept;
  logic                    w_we_eff;
  logic [ADDR_WIDTH-1:0]   w_rd_adr;

  assign w_req    = CYC & STB;
  assign w_busy   = (REFRESH_PERIOD != 0) && (r_ref_cnt < RW'(REFRESH_CYCLES));
  assign w_accept = (r_state == S_IDLE) && w_req && !w_busy;
  // With LATENCY==1 the read is captured on the accepting edge, before r_adr is valid.
  assign w_we_eff = (r_state == S_IDLE) ? WE  : r_we;
  assign w_rd_adr = (r_state == S_IDLE) ? ADR : r_adr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ref_cnt <= '0;
    end else if (REFRESH_PERIOD == 0 || r_ref_cnt == RW'(REFRESH_PERIOD - 1)) begin
      r_ref_cnt <= '0;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_busy)            w_next = S_RETRY;
          else if (LATENCY == 1) w_next = S_RESP;
          else                   w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_req)                 w_next = S_IDLE;
        else if (r_lat_cnt == 8'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      S_RETRY: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_ack     <= 1'b0;
      r_rty     <= 1'b0;
      r_dat_s   <= '0;
      r_lat_cnt <= '0;
      r_adr     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_dat     <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == S_RESP);
      r_rty   <= (w_next == S_RETRY);
      if (w_accept) begin
        r_adr     <= ADR;
        r_we      <= WE;
        r_sel     <= SEL;
        r_dat     <= DAT_M;
        r_lat_cnt <= LAT_M1;
      end else if (r_state == S_WAIT) begin
        r_lat_cnt <= r_lat_cnt - 8'd1;
      end
      if (w_next == S_RESP && !w_we_eff) begin
        r_dat_s <= r_mem[w_rd_adr];
      end
    end
  end

  // Array is deliberately left out of reset so contents survive it.
  always_ff @(posedge CLK) begin
    if (r_state == S_RESP && r_we) begin
      for (int i = 0; i < NB; i++) begin
        if (r_sel[i]) r_mem[r_adr][8*i +: 8] <= r_dat[8*i +: 8];
      end
    end
  end

  assign DAT_S = r_dat_s;
  assign ACK   = r_ack;
  assign RTY   = r_rty;

endmodule
